// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit memory controller.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Reserved size is reported through the same error path as misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake and data-memory bus between datapath, controller and memory.
// req_* and resp_* use valid/ready: a beat transfers on the rising edge where valid && ready;
// the source holds its payload stable while valid is high and ready is low.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [31:0]           mem_wd;
  logic [31:0]           mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_we, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_we, mem_wd
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts/extends load data and merges sub-word store data
// into the previously read memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    case (lane)
      2'd0: byte_v = rd_word[7:0];
      2'd1: byte_v = rd_word[15:8];
      2'd2: byte_v = rd_word[23:16];
      default: byte_v = rd_word[31:24];
    endcase
    half_v = lane[1] ? rd_word[31:16] : rd_word[15:0];

    ld_data = 32'h0;
    case (size)
      SZ_BYTE: ld_data = {{24{sext & byte_v[7]}}, byte_v};
      SZ_HALF: ld_data = {{16{sext & half_v[15]}}, half_v};
      SZ_WORD: ld_data = rd_word;
      default: ld_data = 32'h0;
    endcase
  end

  // Untouched lanes keep the value read from memory so the full-word write is safe.
  always_comb begin
    st_data = rd_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0: st_data[7:0]   = wdata[7:0];
          2'd1: st_data[15:8]  = wdata[7:0];
          2'd2: st_data[23:16] = wdata[7:0];
          default: st_data[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) st_data[31:16] = wdata[15:0];
        else         st_data[15:0]  = wdata[15:0];
      end
      SZ_WORD: st_data = wdata;
      default: st_data = rd_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller in front of a word-wide byte-addressed memory;
// sub-word stores are done as read-modify-write.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_SIZE  = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  lsu_mem_ctrl_if.slave    bus,
  output logic [1:0]       dbg_state
);

  localparam int DATA_W = 8 * BYTE_SIZE;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_READ  = ST_READ;
  localparam logic [1:0] S_WRITE = ST_WRITE;
  localparam logic [1:0] S_RESP  = ST_RESP;

  logic [1:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic                  signed_q;
  logic                  err_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [DATA_W-1:0]     ld_data;
  logic [DATA_W-1:0]     st_data;
  logic                  accept;
  logic                  req_bad;

  assign accept  = bus.req_valid && bus.req_ready;
  assign req_bad = misaligned(bus.req_size, bus.req_addr[1:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_bad)                                state_nxt = S_RESP;
          else if (bus.req_we && bus.req_size == SZ_WORD) state_nxt = S_WRITE;
          else                                        state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = we_q ? S_WRITE : S_RESP;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q   <= bus.req_addr;
        size_q   <= bus.req_size;
        we_q     <= bus.req_we;
        signed_q <= bus.req_signed;
        err_q    <= req_bad;
        wdata_q  <= bus.req_wdata;
      end
      if (state == S_READ) rdata_q <= bus.mem_rd;
    end
  end

  lsu_lane_align u_align (
    .rd_word (rdata_q),
    .wdata   (wdata_q),
    .lane    (addr_q[1:0]),
    .size    (size_q),
    .sext    (signed_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  // All outputs decode from state, so an asynchronous reset clears them at once.
  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_err   = (state == S_RESP) && err_q;
  assign bus.resp_rdata = ((state == S_RESP) && !err_q && !we_q) ? ld_data : '0;
  assign bus.mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_we     = (state == S_WRITE);
  assign bus.mem_wd     = st_data;
  assign dbg_state      = state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed and random load/store traffic against a small memory
// and a shadow model, with expected responses queued at issue time.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .BYTE_SIZE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  logic [31:0] mem   [0:15];
  logic [31:0] model [0:15];

  assign bus.mem_rd = mem[bus.mem_addr[5:2]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wd;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] s;
    logic [31:0] r;
    s = w >> (8 * a);
    r = 32'h0;
    if (sz == 2'd0) begin
      r = {24'h0, s[7:0]};
      if (sg && s[7]) r[31:8] = 24'hFFFFFF;
    end else if (sz == 2'd1) begin
      r = {16'h0, s[15:0]};
      if (sg && s[15]) r[31:16] = 16'hFFFF;
    end else if (sz == 2'd2) begin
      r = w;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] mask;
    if (sz == 2'd2) return wd;
    mask = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    mask = mask << (8 * a);
    return (old & ~mask) | ((wd << (8 * a)) & mask);
  endfunction

  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold);
    int          idx;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_wd;
    int          e_lat;
    int          e_we_at;
    int          n;
    int          we_seen;
    logic        got;
    logic [31:0] wd_seen;
    logic [31:0] ad_seen;
    logic [32:0] e;

    idx     = int'(addr[5:2]);
    e_err   = ref_err(sz, addr[1:0]);
    e_rdata = (e_err || we) ? 32'h0 : ref_load(model[idx], addr[1:0], sz, sg);
    e_wd    = ref_merge(model[idx], wd, addr[1:0], sz);
    e_lat   = e_err ? 1 : ((we && sz != 2'd2) ? 3 : 2);
    e_we_at = (e_err || !we) ? 0 : ((sz == 2'd2) ? 1 : 2);

    @(negedge clk);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    exp_q.push_back({e_err, e_rdata});
    if (!e_err && we) model[idx] = e_wd;

    n = 0;
    we_seen = 0;
    got = 1'b0;
    wd_seen = 32'h0;
    ad_seen = 32'h0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (bus.mem_we) begin
        we_seen = (we_seen == 0) ? n : 99;
        wd_seen = bus.mem_wd;
        ad_seen = bus.mem_addr;
      end
      if (bus.resp_valid) got = 1'b1;
    end
    check({tag, "_latency"}, got ? 64'(n) : 64'd0, 64'(e_lat));
    check({tag, "_we_cycle"}, 64'(we_seen), 64'(e_we_at));
    if (e_we_at != 0) begin
      check({tag, "_mem_wd"}, 64'(wd_seen), 64'(e_wd));
      check({tag, "_mem_addr"}, 64'(ad_seen), 64'({addr[31:2], 2'b00}));
    end
    e = exp_q.pop_front();
    if (!got) begin
      bus.resp_ready = 1'b1;
      return;
    end
    check({tag, "_rdata"}, 64'(bus.resp_rdata), 64'(e[31:0]));
    check({tag, "_err"}, 64'(bus.resp_err), 64'(e[32]));

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(bus.resp_valid), 64'd1);
      check({tag, "_hold_rdata"}, 64'(bus.resp_rdata), 64'(e[31:0]));
      check({tag, "_hold_err"}, 64'(bus.resp_err), 64'(e[32]));
      check({tag, "_hold_req_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_idle_req_ready"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h8899AABB;
    mem[1] = 32'h11223344;
    for (int i = 0; i < 16; i++) model[i] = mem[i];

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    xact("t1_lb_signed", 1'b0, 2'd0, 1'b1, 32'h1, 32'h0, 0);
    xact("t2_lh_unsigned", 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 0);
    xact("t3_sb", 1'b1, 2'd0, 1'b0, 32'h3, 32'h0000005C, 0);
    xact("t3_lw_after", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0);
    xact("t4_lw_misal", 1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 0);
    xact("t4_sh_misal", 1'b1, 2'd1, 1'b0, 32'h1, 32'h0000BEEF, 0);
    xact("t4_rsvd", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0);
    xact("t5_backpressure", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 3);
    xact("t5_next", 1'b0, 2'd0, 1'b0, 32'h3, 32'h0, 0);

    for (int k = 0; k < 30; k++) begin
      xact($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 2));
    end

    // Reset while the word store sits in WRITE, before its edge commits it.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'd2;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h4;
    bus.req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("t6_in_write", 64'(dbg_state), 64'd2);
    check("t6_we_before_rst", 64'(bus.mem_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_we_dropped", 64'(bus.mem_we), 64'd0);
    check("t6_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("t6_resp_err", 64'(bus.resp_err), 64'd0);
    check("t6_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check("t6_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("t6_mem_unchanged", 64'(mem[1]), 64'(model[1]));
    rst_n = 1'b1;
    #1;
    check("t6_req_ready_release", 64'(bus.req_ready), 64'd1);
    xact("t6_lw_after", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the byte-addressed data memory.
- Accepts one datapath request at a time: byte, halfword or word, load or store.
- Issues word-aligned memory accesses and performs read-modify-write for sub-word stores, because the memory always writes all BYTE_SIZE bytes.
- Returns sign- or zero-extended load data over a valid/ready response handshake.

Parameters:
ADDR_WIDTH, 32, width of request and memory addresses
BYTE_SIZE, 4, bytes per memory word; fixed at 4 (data width 32)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  controller can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  input  1  sign-extend loads (ignored for word and for stores)
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  consumer takes response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or reserved-size request
mem_addr  output  ADDR_WIDTH  {addr_q[ADDR_WIDTH-1:2],2'b00}
mem_we  output  1  memory write enable
mem_wd  output  32  memory write data
mem_rd  input  32  memory read data, combinational; byte 0 in bits [7:0] (little-endian)

Behaviour:
- States: IDLE, READ, WRITE, RESP. On reset: state IDLE; resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0; request registers cleared.
- IDLE: req_ready=1. On req_valid&&req_ready (cycle T), latch addr/size/we/signed/wdata. Lane = addr[1:0].
- Error check on latch:
  - half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> RESP with resp_err=1.
  - No memory write ever occurs on error.
- Next state after accept: load or sub-word store -> READ; word store -> WRITE.
- READ: drive mem_addr; capture mem_rd into rdata_q at the clock edge. Then load -> RESP, store -> WRITE.
- WRITE: mem_we=1 for exactly this one cycle; mem_wd = rdata_q with the selected lane(s) replaced by req_wdata[7:0] or [15:0]. For word stores, mem_wd = wdata_q. Next state RESP.
- mem_we is decoded from state, so an asynchronous reset deasserts it immediately.
- Load extraction:
  - byte = rdata_q[8*lane +: 8]; half = rdata_q[8*lane +: 16] with lane 0 or 2.
  - Extend with bit 7 / bit 15 if signed, else zero-extend.
- RESP: resp_valid=1; resp_rdata/resp_err held stable until resp_ready. On resp_valid&&resp_ready -> IDLE. Next request is accepted no earlier than the following cycle.
- Latencies (resp_valid first high):
  - load T+2
  - word store T+2
  - sub-word store T+3
  - error T+1
- mem_addr is held at the latched aligned address in READ and WRITE; it is don't-care in IDLE and RESP.
- Reset mid-operation (any state): return to IDLE. The request is dropped, no response is produced, and a write not yet clocked is aborted.
- req_valid with req_ready=0 is ignored; the upstream stage holds the request.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - state enum IDLE/READ/WRITE/RESP
  - function misaligned(size, lane)
- Sub-module lsu_lane_align (combinational):
  - load path: extract + extend from (word, lane, size, signed)
  - store path: merge from (old word, wdata, lane, size)
  - FSM lives in lsu_mem_ctrl.

Test Plan:
1. Memory bytes 0..3 = BB AA 99 88 (word 0x8899AABB); signed byte load addr 1 at T -> resp_valid at T+2, resp_rdata=0xFFFFFFAA, resp_err=0.
2. Same memory; unsigned half load addr 2 -> resp_rdata=0x00008899 at T+2.
3. Byte store 0x5C at addr 3 -> mem_we high only at T+2, mem_addr=0, mem_wd=0x5C99AABB; resp at T+3; subsequent word load addr 0 returns 0x5C99AABB.
4. Word load addr 2 -> resp_err=1 at T+1, resp_rdata=0, mem_we never asserted. Half store addr 1 -> same error behaviour.
5. Backpressure: load completes with resp_ready held low 3 cycles -> resp_valid, resp_rdata and resp_err stable throughout, req_ready=0. Release resp_ready -> IDLE next cycle, new request accepted.
6. Word store 0xDEADBEEF addr 4; assert rst_n=0 mid-cycle while in WRITE -> mem_we drops immediately, memory word 4 unchanged, outputs at reset values, req_ready=1 after release.
